// File: rtl/ram_arb_mc_if.sv
// Request/response bus between the masters and the ram_arb_mc storage arbiter.
// The master side drives requests and the clear pulse. The slave side
// returns the grants, read responses and init status.
`timescale 1ns/1ps
interface ram_arb_mc_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int NUM_CH  = 2
);
    logic                        clr_req;
    logic                        init_done;
    logic [NUM_CH-1:0]           req_valid;
    logic [NUM_CH-1:0]           req_ready;
    logic [NUM_CH-1:0]           req_we;
    logic [NUM_CH*A_WIDTH-1:0]   req_addr;
    logic [NUM_CH*D_WIDTH-1:0]   req_wdata;
    logic [NUM_CH*D_WIDTH/8-1:0] req_be;
    logic [NUM_CH-1:0]           rsp_valid;
    logic [D_WIDTH-1:0]          rsp_rdata;

    modport master (
        output clr_req, req_valid, req_we, req_addr, req_wdata, req_be,
        input  init_done, req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  clr_req, req_valid, req_we, req_addr, req_wdata, req_be,
        output init_done, req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_arb_mc.sv
// Multi-channel single-port RAM with a round-robin arbiter.
// It supports byte-enable writes and a RD_LAT-deep read pipeline.
// A clear sequencer zeroes the array after reset or on clr_req.
`timescale 1ns/1ps
module ram_arb_mc #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int NUM_CH  = 2,
    parameter int RD_LAT  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arb_mc_if.slave  bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam int BE_W  = D_WIDTH / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [A_WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic               init_done_r, init_done_nxt_s;
    logic [CH_W-1:0]    prio_r, prio_nxt_s;
    logic [D_WIDTH-1:0] mem_r [DEPTH];

    logic [NUM_CH-1:0]  gnt_s;
    logic [CH_W-1:0]    gnt_idx_s;
    logic               accept_s;
    logic               clear_we_s;
    logic               sel_we_s;
    logic [A_WIDTH-1:0] sel_addr_s;
    logic [D_WIDTH-1:0] sel_wdata_s;
    logic [BE_W-1:0]    sel_be_s;

    logic [NUM_CH-1:0]  pipe_vld_r [RD_LAT];
    logic [D_WIDTH-1:0] pipe_dat_r [RD_LAT];

    // Replace only the byte lanes whose enable is set.
    function automatic logic [D_WIDTH-1:0] byte_merge(
        input logic [D_WIDTH-1:0] old_w,
        input logic [D_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]    be
    );
        logic [D_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Round-robin grant. The search starts at prio_r and only runs in RUN.
    always_comb begin
        int  idx_v;
        logic found_v;
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_v   = 1'b0;
        idx_v     = 0;
        if (state_r == ST_RUN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx_v = int'(prio_r) + k;
                if (idx_v >= NUM_CH) begin
                    idx_v = idx_v - NUM_CH;
                end else begin
                    idx_v = idx_v;
                end
                if (!found_v && bus.req_valid[idx_v]) begin
                    found_v      = 1'b1;
                    gnt_idx_s    = CH_W'(idx_v);
                    gnt_s[idx_v] = 1'b1;
                end else begin
                    found_v = found_v;
                end
            end
        end else begin
            gnt_s = '0;
        end
    end

    // Mux the granted channel's request fields and compute the next priority pointer.
    always_comb begin
        accept_s    = |gnt_s;
        sel_we_s    = bus.req_we[gnt_idx_s];
        sel_addr_s  = bus.req_addr[gnt_idx_s*A_WIDTH +: A_WIDTH];
        sel_wdata_s = bus.req_wdata[gnt_idx_s*D_WIDTH +: D_WIDTH];
        sel_be_s    = bus.req_be[gnt_idx_s*BE_W +: BE_W];
        clear_we_s  = (state_r == ST_CLEAR) && rst_n;
        if (!accept_s) begin
            prio_nxt_s = prio_r;
        end else if (int'(gnt_idx_s) == NUM_CH - 1) begin
            prio_nxt_s = '0;
        end else begin
            prio_nxt_s = gnt_idx_s + CH_W'(1);
        end
    end

    // Next state for the clear/run sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        init_done_nxt_s = init_done_r;
        case (state_r)
            ST_CLEAR: begin
                cnt_nxt_s = cnt_r + A_WIDTH'(1);
                if (cnt_r == A_WIDTH'(DEPTH - 1)) begin
                    state_nxt_s     = ST_RUN;
                    init_done_nxt_s = 1'b1;
                end else begin
                    init_done_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.clr_req) begin
                    state_nxt_s     = ST_CLEAR;
                    cnt_nxt_s       = '0;
                    init_done_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s     = ST_CLEAR;
                cnt_nxt_s       = '0;
                init_done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, clear counter, init flag and arbitration pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
            prio_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            init_done_r <= init_done_nxt_s;
            prio_r      <= prio_nxt_s;
        end
    end

    // Storage array. It holds its contents through reset and is zeroed by CLEAR.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= '0;
        end else if (accept_s && sel_we_s) begin
            mem_r[sel_addr_s] <= byte_merge(mem_r[sel_addr_s], sel_wdata_s, sel_be_s);
        end
    end

    // Read pipeline. Data is captured at accept, and idle stages carry zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_r[k] <= '0;
                pipe_dat_r[k] <= '0;
            end
        end else begin
            if (accept_s && !sel_we_s) begin
                pipe_vld_r[0] <= gnt_s;
                pipe_dat_r[0] <= mem_r[sel_addr_s];
            end else begin
                pipe_vld_r[0] <= '0;
                pipe_dat_r[0] <= '0;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_r[k] <= pipe_vld_r[k-1];
                pipe_dat_r[k] <= pipe_dat_r[k-1];
            end
        end
    end

    assign bus.req_ready = gnt_s;
    assign bus.init_done = init_done_r;
    assign bus.rsp_valid = pipe_vld_r[RD_LAT-1];
    assign bus.rsp_rdata = pipe_dat_r[RD_LAT-1];
endmodule

// File: tb/tb_ram_arb_mc.sv
// Bench for ram_arb_mc.
// DUT1 (RD_LAT=2) is checked every cycle against a behavioural model.
// DUT2 (RD_LAT=4) covers a reset applied while a read is in flight.
`timescale 1ns/1ps
module tb_ram_arb_mc;
    localparam int LAT1 = 2;
    localparam int LAT2 = 4;

    logic clk = 1'b0;
    logic rst_n, rst_n2;
    int   errors = 0;
    int   checks = 0;

    ram_arb_mc_if #(.D_WIDTH(32), .A_WIDTH(5), .NUM_CH(2)) bus ();
    ram_arb_mc_if #(.D_WIDTH(32), .A_WIDTH(5), .NUM_CH(2)) bus2 ();

    ram_arb_mc #(.D_WIDTH(32), .A_WIDTH(5), .NUM_CH(2), .RD_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    ram_arb_mc #(.D_WIDTH(32), .A_WIDTH(5), .NUM_CH(2), .RD_LAT(LAT2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of DUT1 ----------------
    logic [31:0] mem_m [32];
    logic        slot_has [8];
    int          slot_ch  [8];
    logic [31:0] slot_dat [8];

    initial begin : model
        int  cyc, g, i, clr_left, prio, a, s;
        logic run;
        logic [31:0] w;
        logic [3:0]  be;
        logic [1:0]  exp_rdy;
        cyc = 0; run = 1'b0; clr_left = 32; prio = 0;
        for (int k = 0; k < 32; k++) mem_m[k] = 32'h0;
        for (int k = 0; k < 8; k++) begin slot_has[k] = 1'b0; slot_ch[k] = 0; slot_dat[k] = 32'h0; end
        forever begin
            @(negedge clk);
            s = cyc % 8;
            if (!rst_n) begin
                run = 1'b0; clr_left = 32; prio = 0;
                for (int k = 0; k < 8; k++) slot_has[k] = 1'b0;
                chk("rst_ready", {30'h0, bus.req_ready}, 32'h0);
                chk("rst_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
                chk("rst_rdata", bus.rsp_rdata, 32'h0);
                chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
            end else begin
                g = -1;
                if (run) begin
                    for (int k = 0; k < 2; k++) begin
                        i = (prio + k) % 2;
                        if (g < 0 && bus.req_valid[i]) g = i;
                    end
                end
                exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
                chk("ready", {30'h0, bus.req_ready}, {30'h0, exp_rdy});
                chk("init_done", {31'h0, bus.init_done}, {31'h0, run});
                chk("rsp_valid", {30'h0, bus.rsp_valid},
                    slot_has[s] ? (32'h1 << slot_ch[s]) : 32'h0);
                chk("rsp_rdata", bus.rsp_rdata, slot_has[s] ? slot_dat[s] : 32'h0);
                slot_has[s] = 1'b0;
                if (run) begin
                    if (g >= 0) begin
                        a = int'(bus.req_addr[g*5 +: 5]);
                        if (bus.req_we[g]) begin
                            w  = bus.req_wdata[g*32 +: 32];
                            be = bus.req_be[g*4 +: 4];
                            for (int b = 0; b < 4; b++)
                                if (be[b]) mem_m[a][b*8 +: 8] = w[b*8 +: 8];
                        end else begin
                            slot_has[(cyc + LAT1) % 8] = 1'b1;
                            slot_ch[(cyc + LAT1) % 8]  = g;
                            slot_dat[(cyc + LAT1) % 8] = mem_m[a];
                        end
                        prio = (g + 1) % 2;
                    end
                    if (bus.clr_req) begin
                        run = 1'b0; clr_left = 32;
                    end
                end else begin
                    clr_left--;
                    if (clr_left == 0) begin
                        run = 1'b1;
                        for (int k = 0; k < 32; k++) mem_m[k] = 32'h0;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers (DUT1) ----------------
    task automatic do_req(input int ch, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        int n;
        bus.req_we[ch] = we;
        bus.req_addr[ch*5 +: 5] = addr;
        bus.req_wdata[ch*32 +: 32] = wdata;
        bus.req_be[ch*4 +: 4] = be;
        bus.req_valid[ch] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready[ch]) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL req_timeout: ch%0d not granted within 50 clks", ch);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic read_chk(input int ch, input logic [4:0] addr,
                            input logic [31:0] exp, input string name);
        int k;
        logic got;
        do_req(ch, 1'b0, addr, 32'h0, 4'h0);
        got = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[ch]) begin
                got = 1'b1;
                chk({name, "_lat"}, k, LAT1);
                chk({name, "_data"}, bus.rsp_rdata, exp);
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_noresp: no response within 10 clks", name);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int n, bad, k;
        logic [1:0] gs [6];
        logic got;
        bus.clr_req = 1'b0; bus.req_valid = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
        bus2.clr_req = 1'b0; bus2.req_valid = '0; bus2.req_we = '0;
        bus2.req_addr = '0; bus2.req_wdata = '0; bus2.req_be = '0;
        rst_n = 1'b1; rst_n2 = 1'b1;
        #1 rst_n = 1'b0; rst_n2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; rst_n2 = 1'b1;

        // 1: CLEAR lasts 32 clocks, then the array reads zero
        n = 0;
        @(negedge clk);
        while (!bus.init_done && n < 100) begin n++; @(negedge clk); end
        chk("t1_clear_clks", n, 32);
        @(posedge clk); #1;
        read_chk(0, 5'h10, 32'h0000_0000, "t1_rd10");

        // 2: write and read back with latency 2
        do_req(0, 1'b1, 5'h10, 32'h0000_00ff, 4'hF);
        read_chk(0, 5'h10, 32'h0000_00ff, "t2_rd10");

        // 3: ch1 no-op write (be=0) moves priority to ch0, then alternate grants
        do_req(1, 1'b1, 5'h00, 32'hDEAD_BEEF, 4'h0);
        bus.req_we = 2'b00;
        bus.req_addr = {5'h00, 5'h10};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); gs[i] = bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < 6; i++)
            chk("t3_grant_seq", {30'h0, gs[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
        repeat (4) @(posedge clk); #1;
        read_chk(1, 5'h00, 32'h0000_0000, "t3_noop");

        // 4: partial byte-enable write
        do_req(0, 1'b1, 5'h03, 32'hAABB_CCDD, 4'hF);
        do_req(0, 1'b1, 5'h03, 32'h1122_3344, 4'h5);
        read_chk(0, 5'h03, 32'hAA22_CC44, "t4_rd03");

        // 5: clear with a same-cycle read accept
        do_req(0, 1'b1, 5'h1F, 32'h1234_5678, 4'hF);
        bus.req_we[0] = 1'b0; bus.req_addr[4:0] = 5'h1F;
        bus.req_valid[0] = 1'b1; bus.clr_req = 1'b1;
        @(negedge clk);
        chk("t5_accept_with_clr", {31'h0, bus.req_ready[0]}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0; bus.clr_req = 1'b0;
        n = 0; got = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid[0]) begin
                got = 1'b1;
                chk("t5_lat", k, LAT1);
                chk("t5_predata", bus.rsp_rdata, 32'h1234_5678);
            end
            if (!bus.init_done) n++;
        end
        chk("t5_resp_seen", {31'h0, got}, 32'h1);
        chk("t5_clear_clks", n, 32);
        @(posedge clk); #1;
        read_chk(1, 5'h1F, 32'h0000_0000, "t5_rd1f");
        read_chk(0, 5'h10, 32'h0000_0000, "t5_rd10");

        // 6: DUT2 (RD_LAT=4), reset while a read is in flight
        chk("t6_init", {31'h0, bus2.init_done}, 32'h1);
        bus2.req_we[0] = 1'b0; bus2.req_addr[4:0] = 5'h05; bus2.req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t6_ready", {31'h0, bus2.req_ready[0]}, 32'h1);
        @(posedge clk); #1;
        bus2.req_valid[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst_n2 = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus2.rsp_valid != 2'b00 || bus2.init_done || bus2.req_ready != 2'b00) bad++;
        end
        chk("t6_rst_quiet", bad, 0);
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        bus2.req_valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus2.req_ready[0] && n < 100) begin n++; @(negedge clk); end
        chk("t6_clear_clks", n, 32);
        chk("t6_init_after", {31'h0, bus2.init_done}, 32'h1);
        @(posedge clk); #1;
        bus2.req_valid[0] = 1'b0;
        got = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus2.rsp_valid != 2'b00) begin
                got = 1'b1;
                chk("t6_lat", k, LAT2);
                chk("t6_vld", {30'h0, bus2.rsp_valid}, 32'h1);
                chk("t6_data", bus2.rsp_rdata, 32'h0);
                break;
            end
        end
        chk("t6_resp_seen", {31'h0, got}, 32'h1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
